if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered instruction entries (power of two, at least 2).
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0800, meaning the instruction word presented when the buffer is empty.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: fetch presents an instruction this cycle.
REQ-006 SHALL have port in_instr, input, 16 bits: fetched instruction word.
REQ-007 SHALL have port in_pc2, input, 16 bits: PC+2 of the fetched instruction.
REQ-008 SHALL have port in_ready, output, 1 bit: the buffer accepts in_* this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: a head entry is available to decode.
REQ-010 SHALL have port out_instr, output, 16 bits: head instruction, or NOP_INSTR when empty.
REQ-011 SHALL have port out_pc2, output, 16 bits: head PC+2, or 0 when empty.
REQ-012 SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle.
REQ-013 SHALL have port flush, input, 1 bit: a branch/jump redirect discards all entries.
REQ-014 SHALL have port halted, output, 1 bit: a HALT instruction (opcode bits [15:11] = 5'b00000) has been accepted.

Function
REQ-015 Push SHALL occur when in_valid and in_ready are both high and flush is low; pop SHALL occur when out_valid and out_ready are both high and flush is low.
REQ-016 in_ready SHALL be high exactly when count < DEPTH and state is RUN; it SHALL be derived from registered state only, so a push into a full buffer is refused even when a pop occurs in the same cycle.
REQ-017 out_valid SHALL be high when count != 0; out_instr and out_pc2 SHALL reflect the head entry combinationally from storage, giving zero added latency from entry to visibility after the write edge.
REQ-018 When a push and a pop occur together, count SHALL be unchanged, and the write and read pointers SHALL both advance modulo DEPTH.
REQ-019 Pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0; count SHALL be log2(DEPTH)+1 bits wide.
REQ-020 The state machine SHALL have two states, RUN and HALTED.
- RUN -> HALTED on a push whose in_instr[15:11] == 5'b00000.
- HALTED -> RUN on flush.
REQ-021 In HALTED, the buffer SHALL accept no pushes, SHALL continue to drain via pops, and SHALL hold halted = 1 (registered).
REQ-022 flush SHALL take priority over push and pop on the same edge. On that edge, count and both pointers SHALL go to 0 and state SHALL go to RUN; the next cycle SHALL show out_valid = 0.
REQ-023 A pop on an empty buffer and a push while in_ready = 0 SHALL be ignored without any state change.
REQ-024 Stored data SHALL carry no reset requirement; only control state SHALL be reset.

Reset
REQ-025 While rst = 0, the buffer SHALL asynchronously force count = 0, pointers = 0 and state = RUN.
REQ-026 Outputs during reset SHALL be: out_valid = 0, out_instr = NOP_INSTR, out_pc2 = 0, halted = 0, in_ready = 1 after rst deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all entries with no pop reported.

Structure
REQ-028 Opcode constants (OPC_HALT = 5'b00000, OPC_NOP = 5'b00001) and the NOP_INSTR value SHALL live in the shared ISA constants package used by fetch and decode.
REQ-029 Storage SHALL be a separate sub-module, if_id_entry_ram: a DEPTH x 32-bit register array with one write port and one asynchronous read port.
REQ-030 Control logic (count, pointers, state) SHALL stay in if_id_buffer.

Verification
REQ-031 Reset then push {16'h4123, 16'h0002} with out_ready = 0 -> next cycle out_valid = 1, out_instr = 16'h4123, out_pc2 = 16'h0002.
REQ-032 Push 3 entries back-to-back with out_ready = 0 -> in_ready = 0 after the 2nd push; the 3rd entry is not accepted; pops return entries 1 and 2 in order.
REQ-033 With the buffer full, assert in_valid and out_ready together for 6 cycles -> no push while full; after the first pop, alternating traffic wraps the pointers and preserves order.
REQ-034 Push 16'h0000 (HALT) -> halted = 1 and in_ready = 0 the next cycle; queued entries still drain; flush -> halted = 0 and in_ready = 1.
REQ-035 Buffer holding 2 entries, flush + in_valid + out_ready on the same edge -> next cycle out_valid = 0 and count = 0; the in_* entry is dropped.
REQ-036 Pull rst low asynchronously between clock edges with 2 entries held -> out_valid = 0 and out_instr = 16'h0800 immediately, before the next edge.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared ISA constants and IF/ID buffer types, used by fetch, decode and the IF/ID buffer.
package if_id_buffer_pkg;

    localparam logic [4:0] OPC_HALT = 5'b00000;
    localparam logic [4:0] OPC_NOP  = 5'b00001;

    // Canonical bubble: NOP opcode with all operand fields zero (16'h0800).
    localparam logic [15:0] ISA_NOP_INSTR = {OPC_NOP, 11'b0};

    typedef enum logic {
        StRun,
        StHalted
    } buf_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } if_id_entry_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OPC_HALT;
    endfunction

endpackage

// File: rtl/if_id_entry_ram.sv
// IF/ID entry storage: register array with one write port and one asynchronous read port.
module if_id_entry_ram #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned Width = 32,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    // Data only; validity is tracked by the controller, so no reset is needed here.
    logic [Width-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: small instruction FIFO between fetch and decode with HALT stop and flush.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = ISA_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc2,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc2,
    input  logic        out_ready,
    input  logic        flush,
    output logic        halted
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = DEPTH[PtrW:0];

    logic [PtrW:0]   count_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    buf_state_e      state_q;

    logic         push;
    logic         pop;
    if_id_entry_t wr_entry;
    if_id_entry_t head_entry;

    // Registered-only ready: a full buffer refuses a push even if it pops on the same edge.
    assign in_ready  = (state_q == StRun) && (count_q < DepthCnt);
    assign out_valid = (count_q != '0);
    assign halted    = (state_q == StHalted);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Pointers are log2(DEPTH) wide, so the increment wraps DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= StRun;
        end else if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= StRun;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case (state_q)
                StRun: begin
                    if (push && is_halt(in_instr)) begin
                        state_q <= StHalted;
                    end
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StRun;
            endcase
        end
    end

    assign wr_entry.instr = in_instr;
    assign wr_entry.pc2   = in_pc2;

    if_id_entry_ram #(
        .DEPTH (DEPTH),
        .Width ($bits(if_id_entry_t))
    ) u_entry_ram (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    assign out_instr = out_valid ? head_entry.instr : NOP_INSTR;
    assign out_pc2   = out_valid ? head_entry.pc2   : 16'h0000;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed pushes queue expected entries, a monitor checks pops.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic [15:0] in_pc2 = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc2;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    if_id_buffer #(
        .DEPTH     (2),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc2    (in_pc2),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc2   (out_pc2),
        .out_ready (out_ready),
        .flush     (flush),
        .halted    (halted)
    );

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor: a pop happens on the coming edge iff these hold just before it.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %h/%h, expected no entry", out_instr, out_pc2);
            end else begin
                e = exp_q.pop_front();
                check16("pop_instr", out_instr, e[31:16]);
                check16("pop_pc2", out_pc2, e[15:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc2,
                         input logic rdy, input logic fl, input logic accept);
        in_valid  = v;
        in_instr  = instr;
        in_pc2    = pc2;
        out_ready = rdy;
        flush     = fl;
        if (fl) exp_q.delete();
        if (accept) exp_q.push_back({instr, pc2});
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 16'h0000, 16'h0000, rdy, 1'b0, 1'b0);
    endtask

    logic acc_tbl [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset values while rst is held low.
        #2;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check16("rst_out_instr", out_instr, 16'h0800);
        check16("rst_out_pc2", out_pc2, 16'h0000);
        check_bit("rst_halted", halted, 1'b0);
        #10 rst = 1'b1;
        step();
        check_bit("post_rst_in_ready", in_ready, 1'b1);

        // Single push becomes visible the next cycle.
        drive(1'b1, 16'h4123, 16'h0002, 1'b0, 1'b0, 1'b1);
        step();
        idle(1'b0);
        check_bit("t1_out_valid", out_valid, 1'b1);
        check16("t1_out_instr", out_instr, 16'h4123);
        check16("t1_out_pc2", out_pc2, 16'h0002);
        check_bit("t1_in_ready", in_ready, 1'b1);
        idle(1'b1);
        step();
        idle(1'b0);
        check_bit("t1_empty", out_valid, 1'b0);
        check16("t1_empty_instr", out_instr, 16'h0800);

        // Three back-to-back pushes into a depth-2 buffer.
        drive(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0, 1'b1);
        step();
        check_bit("t2_ready_after1", in_ready, 1'b1);
        drive(1'b1, 16'h2222, 16'h0012, 1'b0, 1'b0, 1'b1);
        step();
        check_bit("t2_ready_after2", in_ready, 1'b0);
        drive(1'b1, 16'h3333, 16'h0014, 1'b0, 1'b0, 1'b0);
        step();
        check_bit("t2_ready_after3", in_ready, 1'b0);
        check16("t2_head", out_instr, 16'h1111);
        idle(1'b1);
        step();
        step();
        check_bit("t2_drained", out_valid, 1'b0);
        step();
        check_bit("t2_empty_pop_valid", out_valid, 1'b0);
        check_bit("t2_empty_pop_ready", in_ready, 1'b1);

        // Fill, then simultaneous traffic: first cycle refused, then push+pop wraps pointers.
        drive(1'b1, 16'h5001, 16'h0100, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h5002, 16'h0102, 1'b0, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 6; k++) begin
            check_bit("t3_in_ready", in_ready, acc_tbl[k]);
            drive(1'b1, 16'hA100 + 16'(k), 16'h0500 + 16'(2 * k), 1'b1, 1'b0, acc_tbl[k]);
            step();
        end
        check_bit("t3_one_left", out_valid, 1'b1);
        idle(1'b1);
        step();
        idle(1'b0);
        check_bit("t3_drained", out_valid, 1'b0);

        // HALT stops intake; queued entries drain; flush resumes.
        drive(1'b1, 16'h6001, 16'h0200, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h0000, 16'h0202, 1'b0, 1'b0, 1'b1);
        step();
        check_bit("t4_halted", halted, 1'b1);
        check_bit("t4_in_ready", in_ready, 1'b0);
        drive(1'b1, 16'h7777, 16'h0204, 1'b0, 1'b0, 1'b0);
        step();
        check16("t4_head", out_instr, 16'h6001);
        idle(1'b1);
        step();
        step();
        idle(1'b0);
        check_bit("t4_drained", out_valid, 1'b0);
        check_bit("t4_still_halted", halted, 1'b1);
        check_bit("t4_still_blocked", in_ready, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        step();
        idle(1'b0);
        check_bit("t4_unhalted", halted, 1'b0);
        check_bit("t4_ready_again", in_ready, 1'b1);

        // Flush wins over push and pop on the same edge.
        drive(1'b1, 16'h8001, 16'h0300, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h8002, 16'h0302, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h8003, 16'h0304, 1'b1, 1'b1, 1'b0);
        step();
        idle(1'b0);
        check_bit("t5_out_valid", out_valid, 1'b0);
        check16("t5_count", 16'(dut.count_q), 16'h0000);
        check_bit("t5_in_ready", in_ready, 1'b1);
        drive(1'b1, 16'h8004, 16'h0306, 1'b0, 1'b0, 1'b1);
        step();
        idle(1'b1);
        step();
        idle(1'b0);
        check_bit("t5_drained", out_valid, 1'b0);

        // Asynchronous reset between edges with two entries held.
        drive(1'b1, 16'h9001, 16'h0400, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h9002, 16'h0402, 1'b0, 1'b0, 1'b1);
        step();
        idle(1'b0);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_bit("t6_async_valid", out_valid, 1'b0);
        check16("t6_async_instr", out_instr, 16'h0800);
        check16("t6_async_pc2", out_pc2, 16'h0000);
        check_bit("t6_async_halted", halted, 1'b0);
        #2;
        rst = 1'b1;
        step();
        check_bit("t6_ready", in_ready, 1'b1);
        check_bit("t6_valid", out_valid, 1'b0);

        check16("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
